buzz_scheduler: RTL and testbench
=================================

# buzz_scheduler

Owns the single piezo buzzer and decides what it plays. It arbitrates between short key-click beeps from the keyboard decoder and melody playback requested by the control unit. It sequences melody notes from a small ROM and generates each tone's square wave. It sits between the control unit and the buzzer pin and reports melody completion back to the control unit.

## Interface
- clkFreq, 1000000: system clock frequency in Hz.
- tickFreq, 100: note-timing tick rate in Hz; one tick is 10 ms at the default.
- beepTicks, 5: key-click beep length, in ticks.
- melodyLen, 16: number of ROM entries played per melody, range 1..16.
- clk  in  1  system clock.
- reset  in  1  reset; asynchronous, active-low.
- keyPressed  in  1  one-cycle pulse requesting a key-click beep.
- playReq  in  1  one-cycle pulse requesting melody start.
- abort  in  1  level input; stops melody or beep immediately.
- busy  out  1  high while a melody is playing.
- complete  out  1  one-cycle pulse when a melody finishes naturally.
- noteIdx  out  4  index of the current melody note.
- buzz  out  1  square-wave output to the buzzer.

## Operation
- States:
  - IDLE: nothing playing.
  - BEEP: key-click beep sounding.
  - NOTE: melody note sounding.
  - GAP: one-tick silence between melody notes.
  - DONE: one-cycle state that emits complete.
- IDLE transitions:
  - playReq goes to NOTE with noteIdx=0.
  - keyPressed goes to BEEP.
  - If both arrive in the same cycle, playReq wins and the beep is dropped.
- BEEP:
  - Plays beep pitch code 13 (A5, 880 Hz) for beepTicks ticks, then returns to IDLE.
  - playReq during BEEP preempts the beep and goes to NOTE.
  - keyPressed during BEEP is ignored; the beep is not restarted.
- NOTE:
  - ROM entry = {pitch[3:0], dur[2:0]}.
  - Sounds the pitch for dur+1 ticks, then goes to GAP.
  - pitch 0 is a rest: buzz stays 0 for the full duration.
- GAP:
  - Holds buzz at 0 for one tick.
  - If noteIdx==melodyLen-1, goes to DONE.
  - Otherwise increments noteIdx and goes to NOTE.
- DONE: pulses complete, clears noteIdx, goes to IDLE.
- keyPressed and playReq in NOTE, GAP or DONE are ignored; a new melody never restarts mid-play.
- abort in any non-IDLE state:
  - Next state is IDLE, buzz=0, noteIdx=0.
  - complete is not pulsed.
  - abort takes priority over every request in the same cycle.
- Tone generation:
  - Half-period counter reloads with halfPeriod[pitch] = clkFreq/(2*freqHz[pitch]), truncated.
  - buzz toggles on each counter expiry.
  - The counter restarts and buzz is forced to 0 on every note/state entry.
- Tick generator:
  - Free-running divider, period clkFreq/tickFreq cycles; runs in all states.
  - The duration counter is loaded on state entry and decremented on each tick.
  - A note therefore lasts between dur and dur+1 full ticks, since the first tick is partial.
- busy = (state ∈ {NOTE, GAP}).

## Timing
- Reset values: busy=0, complete=0, noteIdx=0, buzz=0, state=IDLE, all counters 0. Reset mid-melody silences buzz asynchronously.
- playReq or keyPressed at edge N gives the new state visible at edge N+1; busy rises at N+1.
- First buzz rising edge occurs halfPeriod cycles after state entry.
- complete is high exactly one cycle (DONE), coincident with busy=0; the next cycle is IDLE.
- noteIdx updates on the GAP→NOTE edge and wraps only via DONE; it never exceeds melodyLen-1.

## Configuration
- BUZZ_KEYBEEP_EN defined: BEEP state and keyPressed arbitration are present as above.
- BUZZ_KEYBEEP_EN undefined:
  - keyPressed is ignored and BEEP is unreachable or omitted.
  - beepTicks is unused.
  - All melody behaviour is identical.

## Structure
- Package buzz_pkg holds:
  - state enum (IDLE, BEEP, NOTE, GAP, DONE);
  - PITCH_W=4 and DUR_W=3;
  - the 16-entry freqHz table (0 = rest, 1..15 = C4..C6 diatonic);
  - BEEP_PITCH=13.
- Sub-module melody_rom: combinational 16×7 lookup, noteIdx → {pitch, dur}.
- The top holds the FSM, tick divider, duration counter and tone counter.

## Test plan
- Simulation parameters: clkFreq=100000, tickFreq=100, so one tick = 1000 cycles.
- Reset asserted mid-NOTE → buzz=0, busy=0 and noteIdx=0 immediately, before the next clk edge.
- keyPressed in IDLE → buzz toggles every 56 cycles for 4–5 ticks, then IDLE; busy stays 0 and complete stays 0.
- playReq with a ROM of 16 notes each dur=0 → complete pulses once, width 1 cycle, after 16 notes plus 16 gaps, about 32 ticks; noteIdx steps 0..15.
- playReq and keyPressed in the same cycle → NOTE entered, no BEEP; a second playReq while busy does not reset noteIdx.
- abort at noteIdx=5 → IDLE next cycle, buzz=0, no complete pulse; a following playReq restarts at noteIdx=0.
- Build without BUZZ_KEYBEEP_EN, pulse keyPressed → buzz stays 0 and the state stays IDLE.

Source files
------------

// File: rtl/buzz_pkg.sv
// Shared types and constants for the buzzer scheduler: FSM states, ROM field
// widths and the pitch-code to frequency table (0 = rest, 1..15 = C4..C6 diatonic).
package buzz_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BEEP,
        NOTE,
        GAP,
        DONE
    } state_t;

    localparam int PITCH_W = 4;
    localparam int DUR_W   = 3;

    localparam int FREQ_HZ [16] = '{
        0,   262, 294, 330, 349, 392, 440, 494,
        523, 587, 659, 698, 784, 880, 988, 1047
    };

    localparam logic [PITCH_W-1:0] BEEP_PITCH = 4'd13;

endpackage

// File: rtl/melody_rom.sv
// Combinational melody table: note index -> {pitch code, duration-1 in ticks}.
module melody_rom
    import buzz_pkg::*;
(
    input  logic [3:0]         i_addr,
    output logic [PITCH_W-1:0] o_pitch,
    output logic [DUR_W-1:0]   o_dur
);

    logic [PITCH_W+DUR_W-1:0] w_entry;

    always_comb begin
        w_entry = '0;
        case (i_addr)
            4'd0:  w_entry = {4'd1,  3'd0};
            4'd1:  w_entry = {4'd3,  3'd0};
            4'd2:  w_entry = {4'd5,  3'd1};
            4'd3:  w_entry = {4'd8,  3'd0};
            4'd4:  w_entry = {4'd0,  3'd0};
            4'd5:  w_entry = {4'd5,  3'd0};
            4'd6:  w_entry = {4'd6,  3'd0};
            4'd7:  w_entry = {4'd5,  3'd1};
            4'd8:  w_entry = {4'd4,  3'd0};
            4'd9:  w_entry = {4'd3,  3'd0};
            4'd10: w_entry = {4'd2,  3'd0};
            4'd11: w_entry = {4'd0,  3'd0};
            4'd12: w_entry = {4'd13, 3'd0};
            4'd13: w_entry = {4'd12, 3'd0};
            4'd14: w_entry = {4'd15, 3'd0};
            4'd15: w_entry = {4'd8,  3'd1};
            default: w_entry = '0;
        endcase
    end

    assign o_pitch = w_entry[PITCH_W+DUR_W-1:DUR_W];
    assign o_dur   = w_entry[DUR_W-1:0];

endmodule

// File: rtl/buzz_scheduler.sv
// Piezo owner: arbitrates key-click beeps against ROM melody playback and makes the tone.
// Define BUZZ_KEYBEEP_EN to enable the key-click BEEP path; otherwise keyPressed is ignored.
module buzz_scheduler
    import buzz_pkg::*;
#(
    parameter int clkFreq   = 1000000,
    parameter int tickFreq  = 100,
    parameter int beepTicks = 5,
    parameter int melodyLen = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_keyPressed,
    input  logic       i_playReq,
    input  logic       i_abort,
    output logic       o_busy,
    output logic       o_complete,
    output logic [3:0] o_noteIdx,
    output logic       o_buzz
);

    localparam int         TICK_DIV = clkFreq / tickFreq;
    localparam logic [3:0] LAST_IDX = 4'(melodyLen - 1);

    // Rest (code 0) has no frequency, so its half period is left at zero and never used.
    function automatic logic [31:0] halfPeriodOf(input logic [PITCH_W-1:0] pitch);
        logic [31:0] hp;
        hp = '0;
        for (int i = 1; i < 16; i++)
            if (pitch == PITCH_W'(i))
                hp = 32'(clkFreq / (2 * FREQ_HZ[i]));
        return hp;
    endfunction

    state_t             r_state, w_nextState;
    logic [3:0]         r_noteIdx, w_nextIdx;
    logic [31:0]        r_tickCnt;
    logic [7:0]         r_durCnt, w_entryDur;
    logic [31:0]        r_toneCnt, r_halfPeriod;
    logic [PITCH_W-1:0] r_pitch, w_entryPitch, w_romPitch;
    logic [DUR_W-1:0]   w_romDur;
    logic               r_buzz;
    logic               w_tick, w_durDone, w_enter;

    melody_rom u_rom (
        .i_addr  (w_nextIdx),
        .o_pitch (w_romPitch),
        .o_dur   (w_romDur)
    );

    assign w_tick    = (r_tickCnt == 32'(TICK_DIV - 1));
    assign w_durDone = w_tick && (r_durCnt == 8'd1);
    assign w_enter   = (w_nextState != r_state);

`ifndef BUZZ_KEYBEEP_EN
    logic w_unusedKey;
    assign w_unusedKey = i_keyPressed;
`endif

    // abort outranks every request; a running melody cannot be restarted.
    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_noteIdx;
        if (i_abort) begin
            if (r_state != IDLE) begin
                w_nextState = IDLE;
                w_nextIdx   = 4'd0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_playReq) begin
                        w_nextState = NOTE;
                        w_nextIdx   = 4'd0;
                    end
`ifdef BUZZ_KEYBEEP_EN
                    else if (i_keyPressed) begin
                        w_nextState = BEEP;
                    end
`endif
                end
`ifdef BUZZ_KEYBEEP_EN
                BEEP: begin
                    if (i_playReq) begin
                        w_nextState = NOTE;
                        w_nextIdx   = 4'd0;
                    end else if (w_durDone) begin
                        w_nextState = IDLE;
                    end
                end
`endif
                NOTE: begin
                    if (w_durDone)
                        w_nextState = GAP;
                end
                GAP: begin
                    if (w_durDone) begin
                        if (r_noteIdx == LAST_IDX) begin
                            w_nextState = DONE;
                        end else begin
                            w_nextState = NOTE;
                            w_nextIdx   = r_noteIdx + 4'd1;
                        end
                    end
                end
                DONE: begin
                    w_nextState = IDLE;
                    w_nextIdx   = 4'd0;
                end
                default: begin
                    w_nextState = IDLE;
                    w_nextIdx   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_entryPitch = '0;
        w_entryDur   = 8'd0;
        case (w_nextState)
            NOTE: begin
                w_entryPitch = w_romPitch;
                w_entryDur   = {5'd0, w_romDur} + 8'd1;
            end
            BEEP: begin
                w_entryPitch = BEEP_PITCH;
                w_entryDur   = 8'(beepTicks);
            end
            GAP:     w_entryDur = 8'd1;
            default: w_entryDur = 8'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_noteIdx <= 4'd0;
            r_tickCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_noteIdx <= w_nextIdx;
            r_tickCnt <= w_tick ? '0 : r_tickCnt + 32'd1;
        end
    end

    // Every state entry reloads duration and restarts the tone from a low half-cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_durCnt     <= 8'd0;
            r_toneCnt    <= '0;
            r_halfPeriod <= '0;
            r_pitch      <= '0;
            r_buzz       <= 1'b0;
        end else if (w_enter) begin
            r_durCnt     <= w_entryDur;
            r_toneCnt    <= '0;
            r_halfPeriod <= halfPeriodOf(w_entryPitch);
            r_pitch      <= w_entryPitch;
            r_buzz       <= 1'b0;
        end else begin
            if (w_tick && r_durCnt != 8'd0)
                r_durCnt <= r_durCnt - 8'd1;
            if (r_pitch != '0) begin
                if (r_toneCnt == r_halfPeriod - 32'd1) begin
                    r_toneCnt <= '0;
                    r_buzz    <= ~r_buzz;
                end else begin
                    r_toneCnt <= r_toneCnt + 32'd1;
                end
            end
        end
    end

    assign o_busy     = (r_state == NOTE) || (r_state == GAP);
    assign o_complete = (r_state == DONE);
    assign o_noteIdx  = r_noteIdx;
    assign o_buzz     = r_buzz;

endmodule

// File: tb/tb_buzz_scheduler.sv
// Randomised and directed bench for buzz_scheduler against a tick/elapsed-time reference model.
// Follows BUZZ_KEYBEEP_EN the same way as the design.
module tb_buzz_scheduler;

    localparam int CLK_FREQ   = 100000;
    localparam int TICK_FREQ  = 100;
    localparam int BEEP_TICKS = 5;
    localparam int MELODY_LEN = 16;
    localparam int TICK_LEN   = CLK_FREQ / TICK_FREQ;

    localparam int M_IDLE = 0, M_BEEP = 1, M_NOTE = 2, M_GAP = 3, M_DONE = 4;

`ifdef BUZZ_KEYBEEP_EN
    localparam int BEEP_ON = 1;
`else
    localparam int BEEP_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       keyPressed = 1'b0;
    logic       playReq = 1'b0;
    logic       abort = 1'b0;
    logic       busy, complete, buzz;
    logic [3:0] noteIdx;

    int freqHz [16]    = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988, 1047};
    int tunePitch [16] = '{1, 3, 5, 8, 0, 5, 6, 5, 4, 3, 2, 0, 13, 12, 15, 8};
    int tuneDur [16]   = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};

    int compareCount = 0;
    int mismatchCount = 0;

    int mMode, mIdx, mLeft, mPitch, mEntry, mEdge;

    buzz_scheduler #(
        .clkFreq   (CLK_FREQ),
        .tickFreq  (TICK_FREQ),
        .beepTicks (BEEP_TICKS),
        .melodyLen (MELODY_LEN)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_keyPressed (keyPressed),
        .i_playReq    (playReq),
        .i_abort      (abort),
        .o_busy       (busy),
        .o_complete   (complete),
        .o_noteIdx    (noteIdx),
        .o_buzz       (buzz)
    );

    always #5 clk = ~clk;

    // Reference: what is playing, how many tick boundaries remain, and when it began.
    task automatic modelStep();
        bit tick, finished;
        int nMode, nIdx;
        tick     = (mEdge % TICK_LEN) == TICK_LEN - 1;
        finished = tick && (mLeft == 1);
        nMode    = mMode;
        nIdx     = mIdx;
        if (abort) begin
            if (mMode != M_IDLE) begin
                nMode = M_IDLE;
                nIdx  = 0;
            end
        end else if (mMode == M_IDLE) begin
            if (playReq) begin
                nMode = M_NOTE;
                nIdx  = 0;
            end else if (keyPressed && BEEP_ON == 1) begin
                nMode = M_BEEP;
            end
        end else if (mMode == M_BEEP) begin
            if (playReq) begin
                nMode = M_NOTE;
                nIdx  = 0;
            end else if (finished) begin
                nMode = M_IDLE;
            end
        end else if (mMode == M_NOTE) begin
            if (finished) nMode = M_GAP;
        end else if (mMode == M_GAP) begin
            if (finished) begin
                if (mIdx == MELODY_LEN - 1) nMode = M_DONE;
                else begin
                    nMode = M_NOTE;
                    nIdx  = mIdx + 1;
                end
            end
        end else begin
            nMode = M_IDLE;
            nIdx  = 0;
        end
        if (nMode != mMode) begin
            mEntry = mEdge;
            mPitch = 0;
            mLeft  = 0;
            if (nMode == M_NOTE) begin
                mPitch = tunePitch[nIdx];
                mLeft  = tuneDur[nIdx] + 1;
            end else if (nMode == M_BEEP) begin
                mPitch = 13;
                mLeft  = BEEP_TICKS;
            end else if (nMode == M_GAP) begin
                mLeft = 1;
            end
        end else if (tick && mLeft > 0) begin
            mLeft = mLeft - 1;
        end
        mMode = nMode;
        mIdx  = nIdx;
        mEdge = mEdge + 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mMode  = M_IDLE;
            mIdx   = 0;
            mLeft  = 0;
            mPitch = 0;
            mEntry = 0;
            mEdge  = 0;
        end else begin
            modelStep();
        end
    end

    function automatic int expectedBuzz();
        int hp;
        if ((mMode == M_NOTE || mMode == M_BEEP) && mPitch != 0) begin
            hp = CLK_FREQ / (2 * freqHz[mPitch]);
            return ((mEdge - 1 - mEntry) / hp) % 2;
        end
        return 0;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed != expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkCycle();
        checkOutput("busy", int'(busy), int'(mMode == M_NOTE || mMode == M_GAP));
        checkOutput("complete", int'(complete), int'(mMode == M_DONE));
        checkOutput("noteIdx", int'(noteIdx), mIdx);
        checkOutput("buzz", int'(buzz), expectedBuzz());
    endtask

    // Drive one cycle's inputs at a falling edge, then check at the next falling edge.
    task automatic applyStimulus(input logic kp, input logic pr, input logic ab);
        keyPressed = kp;
        playReq    = pr;
        abort      = ab;
        @(negedge clk);
        checkCycle();
    endtask

    initial begin
        int sawBusy, sawComplete, toggles, completes, maxIdx;
        logic lastBuzz;
        bit doneSeen;

        repeat (3) @(negedge clk);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetComplete", int'(complete), 0);
        checkOutput("resetIdx", int'(noteIdx), 0);
        checkOutput("resetBuzz", int'(buzz), 0);
        rst_n = 1'b1;

        $display("[TB] async reset during a sounding note");
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8000 && noteIdx != 4'd2; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reachIdx2", int'(noteIdx), 2);
        for (int i = 0; i < 400 && buzz != 1'b1; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("buzzHighBeforeReset", int'(buzz), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetBuzz", int'(buzz), 0);
        checkOutput("asyncResetBusy", int'(busy), 0);
        checkOutput("asyncResetIdx", int'(noteIdx), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] key-click beep from idle");
        applyStimulus(1'b1, 1'b0, 1'b0);
        sawBusy = 0;
        sawComplete = 0;
        toggles = 0;
        lastBuzz = buzz;
        for (int i = 0; i < 6000; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (busy) sawBusy = 1;
            if (complete) sawComplete = 1;
            if (buzz != lastBuzz) toggles++;
            lastBuzz = buzz;
        end
        checkOutput("beepBusy", sawBusy, 0);
        checkOutput("beepComplete", sawComplete, 0);
        checkOutput("beepSounded", int'(toggles > 0), BEEP_ON);

        $display("[TB] full melody, simultaneous requests, replay while busy");
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("bothStartsNote", int'(busy), 1);
        completes = 0;
        maxIdx = 0;
        doneSeen = 1'b0;
        for (int i = 0; i < 45000; i++) begin
            if (i == 3000) applyStimulus(1'b1, 1'b1, 1'b0);
            else applyStimulus(1'b0, 1'b0, 1'b0);
            if (int'(noteIdx) > maxIdx) maxIdx = int'(noteIdx);
            if (complete) begin
                completes++;
                doneSeen = 1'b1;
            end else if (doneSeen) begin
                break;
            end
        end
        checkOutput("completeCycles", completes, 1);
        checkOutput("maxNoteIdx", maxIdx, MELODY_LEN - 1);
        checkOutput("idleAfterDone", int'(busy), 0);

        $display("[TB] abort at note 5 then restart");
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 15000 && noteIdx != 4'd5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reachIdx5", int'(noteIdx), 5);
        repeat (100) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("abortBusy", int'(busy), 0);
        checkOutput("abortBuzz", int'(buzz), 0);
        checkOutput("abortIdx", int'(noteIdx), 0);
        checkOutput("abortComplete", int'(complete), 0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("restartBusy", int'(busy), 1);
        checkOutput("restartIdx", int'(noteIdx), 0);
        repeat (1500) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] random request traffic");
        for (int i = 0; i < 15000; i++) begin
            applyStimulus(logic'($urandom_range(0, 199) == 0),
                          logic'($urandom_range(0, 599) == 0),
                          logic'($urandom_range(0, 2999) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
